// File: rtl/dram_pkg.sv
// Shared types and default geometry for the DRAM arbiter and its clear engine.
package dram_pkg;

  localparam int AW_DEF    = 15;
  localparam int DW_DEF    = 18;
  localparam int DEPTH_DEF = 32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } dram_state_e;

endpackage

// File: rtl/dram_clr.sv
// Clear-sweep address counter: walks 0..DEPTH-1 while enabled, restarts at 0 when disabled.
module dram_clr #(
  parameter int AW    = 15,
  parameter int DEPTH = 32768
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic          en_i,
  output logic [AW-1:0] addr_o,
  output logic          done_o
);

  logic [AW-1:0] cnt_q, cnt_d;

  // done marks the cycle that writes the last address; the counter parks there
  assign done_o = en_i && (cnt_q == AW'(DEPTH - 1));
  assign addr_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i)
      cnt_d = '0;
    else if (!done_o)
      cnt_d = cnt_q + AW'(1);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dram_arbiter.sv
// Data-RAM arbiter: clears the RAM after start rises, then gives the DSP priority
// over a request/ack host port; the host owns the RAM while idle.
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          dsp_req,
  input  logic          dsp_wen,
  input  logic [AW-1:0] dsp_addr,
  input  logic [DW-1:0] dsp_wdata,
  output logic [DW-1:0] dsp_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          dsp_ready,
  output logic          clr_busy,
  output logic [7:0]    host_wait
);

  dram_state_e   state_q, state_d;
  logic          start_q;
  logic          host_ack_q;
  logic [DW-1:0] host_rdata_q;
  logic [7:0]    host_wait_q, host_wait_d;
  logic [AW-1:0] ram_addr_q;
  logic [AW-1:0] clr_addr;
  logic          clr_done;
  logic          dsp_sel;
  logic          grant;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  dram_clr #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_clr (
    .mclk    (mclk),
    .reset_n (reset_n),
    .en_i    (state_q == CLEAR),
    .addr_o  (clr_addr),
    .done_o  (clr_done)
  );

  assign dsp_sel = (state_q == RUN) && dsp_req;
  // No grant in an ack cycle, so a held request is served at most every other cycle
  assign grant   = host_req && !host_ack_q &&
                   ((state_q == IDLE) || ((state_q == RUN) && !dsp_req));

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!start_q) state_d = CLEAR;
        CLEAR:   if (clr_done) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dsp_ready = 1'b0;
    clr_busy  = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = ram_addr_q;
    ram_wdata = '0;
    case (state_q)
      CLEAR: begin
        clr_busy = 1'b1;
        ram_wen  = 1'b1;
        ram_addr = clr_addr;
      end
      RUN:     dsp_ready = 1'b1;
      default: ;
    endcase
    if (dsp_sel) begin
      ram_wen   = dsp_wen;
      ram_addr  = dsp_addr;
      ram_wdata = dsp_wdata;
    end else if (grant) begin
      ram_wen   = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  always_comb begin
    host_wait_d = host_wait_q;
    if (grant)
      host_wait_d = 8'd0;
    else if (host_req)
      host_wait_d = sat_inc8(host_wait_q);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      host_ack_q   <= 1'b0;
      host_wait_q  <= 8'd0;
      host_rdata_q <= '0;
      ram_addr_q   <= '0;
    end else begin
      host_ack_q   <= grant;
      host_wait_q  <= host_wait_d;
      host_rdata_q <= host_rdata;
      ram_addr_q   <= ram_addr;
    end
  end

  // RAM data arrives in the ack cycle; it is passed through then and held afterwards
  assign host_rdata = host_ack_q ? ram_rdata : host_rdata_q;
  assign host_ack   = host_ack_q;
  assign host_wait  = host_wait_q;
  assign dsp_rdata  = ram_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed sequence with random data, checked every cycle
// against a behavioural model of the arbitration rules and a golden memory.
module tb_dram_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 18;
  localparam int DEPTH = 32768;

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          dsp_req, dsp_wen;
  logic [AW-1:0] dsp_addr;
  logic [DW-1:0] dsp_wdata, dsp_rdata;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_ack;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          dsp_ready, clr_busy;
  logic [7:0]    host_wait;

  always #5 mclk = ~mclk;

  dram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .start      (start),
    .dsp_req    (dsp_req),
    .dsp_wen    (dsp_wen),
    .dsp_addr   (dsp_addr),
    .dsp_wdata  (dsp_wdata),
    .dsp_rdata  (dsp_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .dsp_ready  (dsp_ready),
    .clr_busy   (clr_busy),
    .host_wait  (host_wait)
  );

  // Synchronous RAM, read-before-write, one cycle of read latency
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge mclk) begin
    ram_rdata <= ram[ram_addr];
    if (ram_wen) ram[ram_addr] <= ram_wdata;
  end

  // Reference model state: 0 idle, 1 clearing, 2 running
  int            m_mode, m_sweep, m_wait;
  bit            m_pstart, m_ack, m_dvld;
  logic [DW-1:0] m_ackdata, m_ddata;
  logic [AW-1:0] m_last;
  logic [DW-1:0] gm [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int acks = 0;
  int busy_cnt = 0;
  bit ready_seen = 0;
  bit last_ack = 0;

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic cyc();
    bit            g;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            nmode;
    @(negedge mclk);
    g = host_req && !m_ack && (m_mode == 0 || (m_mode == 2 && !dsp_req));
    if (m_mode == 1) begin
      e_wen = 1'b1; e_addr = AW'(m_sweep); e_data = '0;
    end else if (m_mode == 2 && dsp_req) begin
      e_wen = dsp_wen; e_addr = dsp_addr; e_data = dsp_wdata;
    end else if (g) begin
      e_wen = host_we; e_addr = host_addr; e_data = host_wdata;
    end else begin
      e_wen = 1'b0; e_addr = m_last; e_data = '0;
    end
    ck("ram_wen",   32'(ram_wen),   32'(e_wen));
    ck("ram_addr",  32'(ram_addr),  32'(e_addr));
    ck("ram_wdata", 32'(ram_wdata), 32'(e_data));
    ck("dsp_ready", 32'(dsp_ready), 32'(m_mode == 2));
    ck("clr_busy",  32'(clr_busy),  32'(m_mode == 1));
    ck("host_ack",  32'(host_ack),  32'(m_ack));
    ck("host_wait", 32'(host_wait), 32'(m_wait));
    if (m_ack)  ck("host_rdata", 32'(host_rdata), 32'(m_ackdata));
    if (m_dvld) ck("dsp_rdata",  32'(dsp_rdata),  32'(m_ddata));
    last_ack = host_ack;
    if (host_ack)  acks++;
    if (clr_busy)  busy_cnt++;
    if (dsp_ready) ready_seen = 1'b1;
    m_dvld  = (m_mode == 2) && dsp_req && !dsp_wen;
    m_ddata = gm[dsp_addr];
    if (g) m_ackdata = gm[host_addr];
    if (e_wen) gm[e_addr] = e_data;
    m_ack  = g;
    m_wait = g ? 0 : (host_req ? ((m_wait < 255) ? m_wait + 1 : 255) : m_wait);
    m_last = e_addr;
    nmode = m_mode;
    if (!start) nmode = 0;
    else if (m_mode == 0 && !m_pstart) nmode = 1;
    else if (m_mode == 1 && m_sweep == DEPTH - 1) nmode = 2;
    if (nmode == 1) m_sweep = (m_mode == 1) ? m_sweep + 1 : 0;
    m_mode   = nmode;
    m_pstart = start;
    @(posedge mclk);
    #1;
  endtask

  task automatic rand_dsp();
    dsp_req   = 1'b1;
    dsp_wen   = 1'($urandom);
    dsp_addr  = AW'($urandom_range(0, 63));
    dsp_wdata = DW'($urandom);
  endtask

  initial begin
    int       k;
    int       a0;
    logic [5:0] pat;
    reset_n = 1'b1; start = 1'b1;
    dsp_req = 1'b0; dsp_wen = 1'b0; dsp_addr = '0; dsp_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = DW'($urandom) | DW'(1);
      gm[i]  = '0;
    end
    #2 reset_n = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    ck("rst_ram_wen",   32'(ram_wen),    32'd0);
    ck("rst_ram_addr",  32'(ram_addr),   32'd0);
    ck("rst_host_ack",  32'(host_ack),   32'd0);
    ck("rst_dsp_ready", 32'(dsp_ready),  32'd0);
    ck("rst_clr_busy",  32'(clr_busy),   32'd0);
    ck("rst_host_wait", 32'(host_wait),  32'd0);
    ck("rst_host_rdata",32'(host_rdata), 32'd0);
    @(posedge mclk);
    #1 reset_n = 1'b1;
    m_mode = 0; m_sweep = 0; m_wait = 0; m_pstart = 0; m_ack = 0; m_dvld = 0;
    m_ackdata = '0; m_ddata = '0; m_last = '0;

    // Full sweep straight out of reset
    k = 0;
    while (!ready_seen && k < DEPTH + 20) begin
      cyc();
      k++;
    end
    ck("ready_reached", 32'(ready_seen), 32'd1);
    ck("clear_cycles",  32'(busy_cnt),   32'(DEPTH));
    ck("ram_first_zero", 32'(ram[0]), 32'd0);
    ck("ram_last_zero",  32'(ram[DEPTH-1]), 32'd0);
    k = $urandom_range(1, DEPTH - 2);
    ck("ram_mid_zero",   32'(ram[k]), 32'd0);

    // DSP holds off a waiting host for 10 cycles
    a0 = acks;
    host_req = 1'b1; host_we = 1'b0; host_addr = AW'($urandom); host_wdata = DW'($urandom);
    for (int i = 0; i < 10; i++) begin
      rand_dsp();
      cyc();
    end
    ck("contend_wait10", 32'(host_wait), 32'd10);
    ck("contend_noack",  32'(acks - a0), 32'd0);
    dsp_req = 1'b0;
    cyc();
    ck("contend_ack",    32'(host_ack),  32'd1);
    ck("contend_wait0",  32'(host_wait), 32'd0);
    host_req = 1'b0;
    cyc();

    // Starvation saturates the wait counter
    host_req = 1'b1; host_we = 1'b1; host_addr = AW'($urandom_range(0, 63)); host_wdata = DW'($urandom);
    for (int i = 0; i < 300; i++) begin
      rand_dsp();
      cyc();
    end
    ck("starve_sat", 32'(host_wait), 32'd255);
    dsp_req = 1'b0;
    cyc();
    host_req = 1'b0;
    cyc();

    // Random mix of DSP traffic and a host that holds each request until acked
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) rand_dsp(); else dsp_req = 1'b0;
      if (host_ack) host_req = 1'b0;
      else if (!host_req && $urandom_range(0, 1) == 1) begin
        host_req   = 1'b1;
        host_we    = 1'($urandom);
        host_addr  = AW'($urandom_range(0, 63));
        host_wdata = DW'($urandom);
      end
      cyc();
    end
    dsp_req = 1'b0; host_req = 1'b0;
    cyc();
    cyc();

    // Idle: host write then read back
    start = 1'b0;
    cyc();
    ck("idle_state", 32'(dsp_ready | clr_busy), 32'd0);
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0100; host_wdata = 18'h2A5A5;
    cyc();
    ck("wr_ack", 32'(host_ack), 32'd1);
    host_req = 1'b0;
    cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0100;
    cyc();
    ck("rd_ack",   32'(host_ack),   32'd1);
    ck("rd_rdata", 32'(host_rdata), 32'h2A5A5);
    host_req = 1'b0;
    cyc();

    // Held request: acks on cycles 2, 4 and 6
    a0 = acks;
    host_req = 1'b1; host_we = 1'($urandom); host_addr = AW'($urandom_range(0, 63)); host_wdata = DW'($urandom);
    for (int i = 0; i < 6; i++) begin
      cyc();
      pat[i] = last_ack;
    end
    host_req = 1'b0;
    ck("b2b_count",   32'(acks - a0), 32'd3);
    ck("b2b_pattern", 32'(pat),       32'b101010);
    cyc();

    // Grant in the last idle cycle is still acked during the clear
    start = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = AW'($urandom_range(0, 63));
    cyc();
    ck("lastidle_ack",  32'(host_ack), 32'd1);
    ck("lastidle_busy", 32'(clr_busy), 32'd1);
    host_req = 1'b0;

    // Abort at 0x40 and restart from 0
    k = 0;
    while (m_sweep != 'h40 && k < 200) begin
      cyc();
      k++;
    end
    ck("abort_addr", 32'(ram_addr), 32'h40);
    start = 1'b0;
    cyc();
    ck("abort_idle", 32'(clr_busy), 32'd0);
    cyc();
    start = 1'b1;
    cyc();
    ck("restart_busy", 32'(clr_busy), 32'd1);
    ck("restart_addr", 32'(ram_addr), 32'd0);
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameters: AW, 15, data-RAM address width; DW, 18, data-RAM word width; DEPTH, 32768, words swept by the clear engine.
REQ-002 Ports, each given as name, direction, width, meaning:
- mclk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  DSP run enable (level).
- dsp_req  in  1  DSP access valid this cycle.
- dsp_wen  in  1  DSP write strobe, qualified by dsp_req.
- dsp_addr  in  AW  DSP address.
- dsp_wdata  in  DW  DSP write data.
- dsp_rdata  out  DW  RAM read data to the DSP.
- host_req  in  1  host access request, held until host_ack.
- host_we  in  1  host write (1) or read (0).
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DW  host read data, valid with host_ack.
- ram_wen  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, 1-cycle synchronous read latency.
- dsp_ready  out  1  clear done; DSP may run.
- clr_busy  out  1  clear sweep in progress.
- host_wait  out  8  saturating count of cycles the host request has been pending.

Function
REQ-003 The FSM SHALL have three states: IDLE, CLEAR, RUN.
REQ-004 IDLE: dsp_ready=0 and clr_busy=0; the host owns the RAM; dsp_req is ignored.
REQ-005 IDLE->CLEAR SHALL occur on the first cycle in which start=1 and the registered start of the previous cycle was 0 (rising edge).
REQ-006 CLEAR: the engine SHALL write ram_wdata=0 to addresses 0,1,...,DEPTH-1, one per cycle, with ram_wen=1; clr_busy=1; host and DSP are both blocked.
REQ-007 CLEAR->RUN SHALL occur in the cycle after address DEPTH-1 is written; the clear address counter SHALL not wrap or rewrite address 0.
REQ-008 RUN: dsp_ready=1 and the DSP has absolute priority; in any cycle with dsp_req=1, ram_addr=dsp_addr, ram_wen=dsp_wen and ram_wdata=dsp_wdata.
REQ-009 dsp_rdata SHALL be wired to ram_rdata, valid one cycle after a DSP read address is presented.
REQ-010 start=0 in any state SHALL force IDLE on the next edge; an aborted clear leaves the RAM partially cleared, and the next rising edge of start restarts the sweep at 0.
REQ-011 Host grant is a cycle where host_req=1, host_ack=0 and either the state is IDLE, or the state is RUN with dsp_req=0.
REQ-012 In a host grant cycle, ram_addr=host_addr, ram_wen=host_we and ram_wdata=host_wdata.
REQ-013 host_ack SHALL pulse exactly one cycle after a grant; host_rdata SHALL be ram_rdata registered-through so that it is valid during the ack cycle, for both reads and writes.
REQ-014 No grant SHALL be issued in an ack cycle, so a host that keeps host_req high sees at most one ack per two cycles.
REQ-015 A grant issued in the last IDLE cycle SHALL still be acked even though the state becomes CLEAR.
REQ-016 host_wait increments each cycle with host_req=1 and no grant, saturates at 255, and clears to 0 on host_ack.
REQ-017 When no requester is granted, ram_wen=0, ram_addr holds its last value and ram_wdata=0.
REQ-018 ram_* outputs SHALL be combinational from state and the selected requester, with no added latency.

Reset
REQ-019 reset_n=0 SHALL asynchronously set:
- state to IDLE, clear counter to 0, registered start to 0;
- host_ack, dsp_ready, clr_busy and ram_wen to 0;
- host_wait, host_rdata and ram_addr to 0.
REQ-020 Deassertion with start already 1 SHALL count as a rising edge one cycle after release, and so enter CLEAR.

Structure
REQ-021 A shared package dram_pkg SHALL hold the state enum (IDLE, CLEAR, RUN) and the AW, DW and DEPTH defaults.
REQ-022 One sub-module dram_clr SHALL own the clear address counter and its done flag; the FSM and mux stay in dram_arbiter.

Verification
REQ-023 Reset: hold start=1 through reset, release -> clr_busy=1 from cycle 2, the RAM is written with 0 at addresses 0..DEPTH-1, then dsp_ready=1 exactly DEPTH cycles later.
REQ-024 IDLE host write then read: host write 0x2A5A5 to address 0x0100, then host read of address 0x0100 -> each host_ack arrives 1 cycle after the grant, and host_rdata=0x2A5A5.
REQ-025 RUN contention: dsp_req=1 for 10 cycles while host_req=1 -> no host_ack, host_wait=10; dsp_req drops -> grant next cycle, ack the following cycle, host_wait=0.
REQ-026 Abort: drop start at clear address 0x0040 -> IDLE next cycle, clr_busy=0; raise start again -> the sweep restarts at address 0.
REQ-027 Starvation saturation: dsp_req=1 for 300 cycles with host_req=1 -> host_wait sticks at 255.
REQ-028 Back-to-back host: host_req held high in IDLE for 6 cycles -> exactly 3 acks, on cycles 2, 4 and 6.
